boot_copier: RTL and testbench
==============================

BOOT_COPIER -- requirements
Module: boot_copier

Interface
REQ-001 SHALL have parameter WORDS, default 512, number of 32-bit words copied (1..512).
REQ-002 SHALL have parameter BASE_ADDR, default 24'h000000, destination byte address of word 0 (word-aligned).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a copy.
REQ-006 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse after last word is written.
REQ-008 SHALL have port prom_en  output  1  read enable to the 512x32 PROM.
REQ-009 SHALL have port prom_addr  output  9  PROM word address.
REQ-010 SHALL have port prom_data  input  32  PROM registered read data, valid the cycle after prom_en.
REQ-011 SHALL have port wr_valid  output  1  destination write request.
REQ-012 SHALL have port wr_ready  input  1  destination accepts write when high with wr_valid.
REQ-013 SHALL have port wr_addr  output  24  destination byte address.
REQ-014 SHALL have port wr_data  output  32  destination write data.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LATCH, WRITE, DONE.
REQ-016 IDLE: start=1 -> FETCH, word index idx cleared to 0; start=0 -> stay.
REQ-017 FETCH: prom_en=1, prom_addr=idx for exactly one cycle; -> LATCH.
REQ-018 LATCH: capture prom_data into wr_data register; wr_addr register := BASE_ADDR + 4*idx (24-bit, wrap modulo 2^24); -> WRITE.
REQ-019 WRITE: wr_valid=1; on wr_valid&wr_ready, if idx==WORDS-1 -> DONE, else idx:=idx+1 -> FETCH.
REQ-020 DONE: done=1 for one cycle; -> IDLE.
REQ-021 prom_en SHALL be high only in FETCH; wr_valid high only in WRITE.
REQ-022 wr_addr and wr_data SHALL remain stable while wr_valid=1 and wr_ready=0.
REQ-023 wr_ready low SHALL stall WRITE indefinitely; no PROM read issued meanwhile.
REQ-024 Each word handshake SHALL complete exactly once; no word skipped or repeated.
REQ-025 Minimum cost per word SHALL be 3 cycles (FETCH, LATCH, WRITE with wr_ready=1); full copy of N words with ready always high = 3N cycles from FETCH entry to DONE.
REQ-026 busy SHALL be 1 in FETCH, LATCH, WRITE, DONE; 0 in IDLE.
REQ-027 start while not in IDLE SHALL be ignored, no restart, no queueing.
REQ-028 WORDS=1 SHALL copy word 0 only, then DONE.
REQ-029 idx SHALL be 9 bits; it never exceeds WORDS-1.
REQ-030 wr_ready outside WRITE SHALL have no effect.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, asynchronously, regardless of clk.
REQ-032 Reset values: busy=0, done=0, prom_en=0, prom_addr=0, wr_valid=0, wr_addr=0, wr_data=0, idx=0.
REQ-033 Reset mid-copy SHALL abort: no further wr_valid until a new start after rst release; copy restarts at word 0.
REQ-034 First start accepted SHALL be on the first rising edge with rst=0.

Verification
REQ-035 WORDS=4, BASE_ADDR=0x001000, PROM 0..3 = 0xA0..0xA3, wr_ready=1, start pulse -> writes (0x001000,0xA0),(0x001004,0xA1),(0x001008,0xA2),(0x00100C,0xA3); done pulse 12 cycles after FETCH entry.
REQ-036 Same setup, wr_ready held low 5 cycles on word 2 -> wr_valid high 6 cycles with wr_addr=0x001008, wr_data=0xA2 stable; prom_en stays low during the stall.
REQ-037 start pulsed again while busy during word 1 -> exactly 4 writes total, one done pulse.
REQ-038 rst asserted mid-cycle during WRITE of word 2 -> wr_valid, busy drop without clk edge; new start copies from word 0 with 4 writes.
REQ-039 WORDS=512, BASE_ADDR=0xFFFFF0 -> last wr_addr = (0xFFFFF0 + 2044) mod 2^24 = 0x0007EC; prom_addr reaches 511; 512 writes.
REQ-040 WORDS=1 -> single write of PROM word 0 to BASE_ADDR, done pulse 3 cycles after FETCH entry.

Source files
------------

// File: rtl/boot_copier.sv
// Boot copier: streams WORDS 32-bit words out of a registered-read PROM and
// writes each one to a byte-addressed destination over a valid/ready channel.
module boot_copier #(
   parameter int          WORDS     = 512,
   parameter logic [23:0] BASE_ADDR = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        prom_en,
   output logic [8:0]  prom_addr,
   input  logic [31:0] prom_data,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [23:0] wr_addr,
   output logic [31:0] wr_data
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      WRITE,
      DONE
   } state_t;

   localparam logic [8:0] LAST_IDX = 9'(WORDS - 1);

   state_t      r_state;
   logic [8:0]  r_idx;
   logic        r_busy;
   logic        r_done;
   logic        r_prom_en;
   logic [8:0]  r_prom_addr;
   logic        r_wr_valid;
   logic [23:0] r_wr_addr;
   logic [31:0] r_wr_data;

   logic [23:0] w_byte_offset;

   assign w_byte_offset = {13'd0, r_idx, 2'b00};

   // Outputs are decoded from the state being entered, so every output is a
   // flop and matches the current state exactly (prom_en only in FETCH,
   // wr_valid only in WRITE, busy everywhere but IDLE).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= 9'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_prom_en   <= 1'b0;
         r_prom_addr <= 9'd0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= 24'd0;
         r_wr_data   <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= FETCH;
                  r_idx       <= 9'd0;
                  r_busy      <= 1'b1;
                  r_prom_en   <= 1'b1;
                  r_prom_addr <= 9'd0;
               end
            end
            FETCH: begin
               r_state   <= LATCH;
               r_prom_en <= 1'b0;
            end
            LATCH: begin
               r_state    <= WRITE;
               r_wr_data  <= prom_data;
               r_wr_addr  <= BASE_ADDR + w_byte_offset;
               r_wr_valid <= 1'b1;
            end
            WRITE: begin
               // Address and data are held untouched until the handshake.
               if (wr_ready) begin
                  r_wr_valid <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= FETCH;
                     r_idx       <= r_idx + 9'd1;
                     r_prom_en   <= 1'b1;
                     r_prom_addr <= r_idx + 9'd1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_prom_en  <= 1'b0;
               r_wr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign prom_en   = r_prom_en;
   assign prom_addr = r_prom_addr;
   assign wr_valid  = r_wr_valid;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: three instances (4, 1 and 512 words) with
// behavioural PROMs and a write logger sampled on the falling clock edge.
module tb_boot_copier;

   logic clk = 1'b0;
   logic rst;
   logic start4 = 1'b0, start1 = 1'b0, start512 = 1'b0;
   logic ready4 = 1'b1, ready1 = 1'b1, ready512 = 1'b1;

   logic        busy4, dn4, pe4, wv4;
   logic [8:0]  pa4;
   logic [23:0] wa4;
   logic [31:0] wd4;
   logic [31:0] pd4 = 32'd0;

   logic        busy1, dn1, pe1, wv1;
   logic [8:0]  pa1;
   logic [23:0] wa1;
   logic [31:0] wd1;
   logic [31:0] pd1 = 32'd0;

   logic        busy512, dn512, pe512, wv512;
   logic [8:0]  pa512;
   logic [23:0] wa512;
   logic [31:0] wd512;
   logic [31:0] pd512 = 32'd0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   boot_copier #(.WORDS(4), .BASE_ADDR(24'h001000)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(dn4),
      .prom_en(pe4), .prom_addr(pa4), .prom_data(pd4),
      .wr_valid(wv4), .wr_ready(ready4), .wr_addr(wa4), .wr_data(wd4));

   boot_copier #(.WORDS(1), .BASE_ADDR(24'h123450)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(dn1),
      .prom_en(pe1), .prom_addr(pa1), .prom_data(pd1),
      .wr_valid(wv1), .wr_ready(ready1), .wr_addr(wa1), .wr_data(wd1));

   boot_copier #(.WORDS(512), .BASE_ADDR(24'hFFFFF0)) dut512 (
      .clk(clk), .rst(rst), .start(start512), .busy(busy512), .done(dn512),
      .prom_en(pe512), .prom_addr(pa512), .prom_data(pd512),
      .wr_valid(wv512), .wr_ready(ready512), .wr_addr(wa512), .wr_data(wd512));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read PROM models: data appears the cycle after prom_en.
   always @(posedge clk) begin
      if (pe4)   pd4   <= 32'h000000A0 + {23'd0, pa4};
      if (pe1)   pd1   <= 32'h000000A0 + {23'd0, pa1};
      if (pe512) pd512 <= 32'hDEAD0000 + {23'd0, pa512};
   end

   logic [23:0] a4q[$];
   logic [31:0] d4q[$];
   logic [23:0] a1q[$];
   logic [31:0] d1q[$];
   logic [23:0] a512q[$];
   logic [31:0] d512q[$];
   int done4Cnt = 0, done4Cyc = 0, overlap4 = 0, vld2Cnt = 0;
   int done1Cnt = 0, done1Cyc = 0;
   int done512Cnt = 0, done512Cyc = 0, overlap512 = 0;
   logic [8:0] maxPa512 = 9'd0;

   // Handshakes are logged mid-cycle; inputs only change just after posedge.
   always @(negedge clk) begin
      if (wv4 && ready4) begin a4q.push_back(wa4); d4q.push_back(wd4); end
      if (dn4) begin done4Cnt <= done4Cnt + 1; done4Cyc <= cyc; end
      if (pe4 && wv4) overlap4 <= overlap4 + 1;
      if (wv4 && wa4 == 24'h001008) vld2Cnt <= vld2Cnt + 1;
      if (wv1 && ready1) begin a1q.push_back(wa1); d1q.push_back(wd1); end
      if (dn1) begin done1Cnt <= done1Cnt + 1; done1Cyc <= cyc; end
      if (wv512 && ready512) begin a512q.push_back(wa512); d512q.push_back(wd512); end
      if (dn512) begin done512Cnt <= done512Cnt + 1; done512Cyc <= cyc; end
      if (pe512 && wv512) overlap512 <= overlap512 + 1;
      if (pe512 && pa512 > maxPa512) maxPa512 <= pa512;
   end

   task automatic pulseStart(input int which, output int s);
      @(posedge clk); #1;
      case (which)
         0:       start4 = 1'b1;
         1:       start1 = 1'b1;
         default: start512 = 1'b1;
      endcase
      @(posedge clk); #1;
      start4 = 1'b0; start1 = 1'b0; start512 = 1'b0;
      s = cyc;
   endtask

   task automatic waitIdle(input int which, input int budget, output bit ok);
      logic b;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         b = (which == 0) ? busy4 : (which == 1) ? busy1 : busy512;
         if (!b) begin ok = 1'b1; break; end
      end
   endtask

   task automatic findWord2(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (wv4 && wa4 == 24'h001008) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      bit ok;
      int s;
      rst = 1'b1;
      start4 = 1'b1;
      #3;
      checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b want=0", busy4); end
      checks++; if (dn4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b want=0", dn4); end
      checks++; if (pe4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_prom_en got=%0b want=0", pe4); end
      checks++; if (pa4 !== 9'd0) begin failures++; $display("[TB] FAIL reset_prom_addr got=%h want=0", pa4); end
      checks++; if (wv4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_valid got=%0b want=0", wv4); end
      checks++; if (wa4 !== 24'd0) begin failures++; $display("[TB] FAIL reset_wr_addr got=%h want=0", wa4); end
      checks++; if (wd4 !== 32'd0) begin failures++; $display("[TB] FAIL reset_wr_data got=%h want=0", wd4); end
      checks++; if (busy1 !== 1'b0 || busy512 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_others got=%0b%0b want=00", busy1, busy512); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL start_in_reset busy got=%0b want=0", busy4); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b0;
      s = cyc;
      checks++; if (busy4 !== 1'b1 || pe4 !== 1'b1 || pa4 !== 9'd0) begin failures++; $display("[TB] FAIL first_start busy=%0b prom_en=%0b addr=%0d want 1 1 0", busy4, pe4, pa4); end
      waitIdle(0, 40, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL first_start_timeout busy=%0b want=0", busy4); end
   endtask

   task automatic test_basic_copy;
      bit ok;
      int s, b, d0, o0, v0;
      b = a4q.size(); d0 = done4Cnt; o0 = overlap4; v0 = vld2Cnt;
      pulseStart(0, s);
      waitIdle(0, 40, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_timeout busy=%0b want=0", busy4); end
      checks++; if (a4q.size() - b != 4) begin failures++; $display("[TB] FAIL basic_count got=%0d want=4", a4q.size() - b); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (a4q[b+i] !== 24'h001000 + 24'(4*i) || d4q[b+i] !== 32'hA0 + 32'(i)) begin
            failures++;
            $display("[TB] FAIL basic_word%0d got=(%h,%h) want=(%h,%h)", i, a4q[b+i], d4q[b+i], 24'h001000 + 24'(4*i), 32'hA0 + 32'(i));
         end
      end
      checks++; if (done4Cnt - d0 != 1) begin failures++; $display("[TB] FAIL basic_done_pulses got=%0d want=1", done4Cnt - d0); end
      checks++; if (done4Cyc - s != 12) begin failures++; $display("[TB] FAIL basic_done_latency got=%0d want=12", done4Cyc - s); end
      checks++; if (overlap4 - o0 != 0) begin failures++; $display("[TB] FAIL basic_en_valid_overlap got=%0d want=0", overlap4 - o0); end
      checks++; if (vld2Cnt - v0 != 1) begin failures++; $display("[TB] FAIL basic_word2_valid_cycles got=%0d want=1", vld2Cnt - v0); end
   endtask

   task automatic test_stall;
      bit ok;
      int s, b, v0, o0, bad;
      b = a4q.size(); v0 = vld2Cnt; o0 = overlap4; bad = 0;
      pulseStart(0, s);
      findWord2(ok);
      ready4 = 1'b0;
      checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_find_word2 got=0 want=1"); end
      repeat (5) begin
         @(posedge clk); #1;
         if (wv4 !== 1'b1 || wa4 !== 24'h001008 || wd4 !== 32'hA2 || pe4 !== 1'b0) bad++;
      end
      ready4 = 1'b1;
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stall_stable bad_cycles got=%0d want=0", bad); end
      waitIdle(0, 40, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_timeout busy=%0b want=0", busy4); end
      checks++; if (vld2Cnt - v0 != 6) begin failures++; $display("[TB] FAIL stall_valid_cycles got=%0d want=6", vld2Cnt - v0); end
      checks++; if (a4q.size() - b != 4) begin failures++; $display("[TB] FAIL stall_count got=%0d want=4", a4q.size() - b); end
      checks++; if (a4q[b+2] !== 24'h001008 || d4q[b+2] !== 32'hA2 || a4q[b+3] !== 24'h00100C || d4q[b+3] !== 32'hA3) begin
         failures++; $display("[TB] FAIL stall_words got=(%h,%h)(%h,%h) want=(001008,a2)(00100c,a3)", a4q[b+2], d4q[b+2], a4q[b+3], d4q[b+3]);
      end
      checks++; if (overlap4 - o0 != 0) begin failures++; $display("[TB] FAIL stall_en_valid_overlap got=%0d want=0", overlap4 - o0); end
   endtask

   task automatic test_start_while_busy;
      bit ok;
      int s, b, d0;
      b = a4q.size(); d0 = done4Cnt;
      pulseStart(0, s);
      repeat (3) @(posedge clk);
      #1 start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      waitIdle(0, 40, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL busy_start_timeout busy=%0b want=0", busy4); end
      repeat (15) @(posedge clk);
      #1;
      checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_restart busy=%0b want=0", busy4); end
      checks++; if (a4q.size() - b != 4) begin failures++; $display("[TB] FAIL busy_start_count got=%0d want=4", a4q.size() - b); end
      checks++; if (done4Cnt - d0 != 1) begin failures++; $display("[TB] FAIL busy_start_done got=%0d want=1", done4Cnt - d0); end
      checks++; if (a4q[b+1] !== 24'h001004 || d4q[b+1] !== 32'hA1) begin failures++; $display("[TB] FAIL busy_start_word1 got=(%h,%h) want=(001004,a1)", a4q[b+1], d4q[b+1]); end
   endtask

   task automatic test_reset_mid_write;
      bit ok;
      int s, b, sz, b2;
      b = a4q.size();
      pulseStart(0, s);
      findWord2(ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rstmid_find_word2 got=0 want=1"); end
      #1 rst = 1'b1;
      #1;
      checks++; if (wv4 !== 1'b0 || busy4 !== 1'b0 || pe4 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_async valid=%0b busy=%0b en=%0b want 0 0 0", wv4, busy4, pe4); end
      sz = a4q.size();
      checks++; if (sz - b != 2) begin failures++; $display("[TB] FAIL rstmid_partial_count got=%0d want=2", sz - b); end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (a4q.size() != sz || busy4 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_quiet writes=%0d busy=%0b want 0 0", a4q.size() - sz, busy4); end
      b2 = a4q.size();
      pulseStart(0, s);
      waitIdle(0, 40, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rstmid_restart_timeout busy=%0b want=0", busy4); end
      checks++; if (a4q.size() - b2 != 4) begin failures++; $display("[TB] FAIL rstmid_restart_count got=%0d want=4", a4q.size() - b2); end
      checks++; if (a4q[b2] !== 24'h001000 || d4q[b2] !== 32'hA0 || a4q[b2+3] !== 24'h00100C) begin
         failures++; $display("[TB] FAIL rstmid_restart_words got=(%h,%h) last=%h want=(001000,a0) last=00100c", a4q[b2], d4q[b2], a4q[b2+3]);
      end
   endtask

   task automatic test_words512;
      bit ok;
      int s, b, d0, o0, bad;
      b = a512q.size(); d0 = done512Cnt; o0 = overlap512; bad = 0;
      pulseStart(2, s);
      waitIdle(2, 1600, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL w512_timeout busy=%0b want=0", busy512); end
      checks++; if (a512q.size() - b != 512) begin failures++; $display("[TB] FAIL w512_count got=%0d want=512", a512q.size() - b); end
      checks++; if (a512q[b] !== 24'hFFFFF0) begin failures++; $display("[TB] FAIL w512_first_addr got=%h want=fffff0", a512q[b]); end
      checks++; if (a512q[b+4] !== 24'h000000) begin failures++; $display("[TB] FAIL w512_wrap_addr got=%h want=000000", a512q[b+4]); end
      checks++; if (a512q[b+511] !== 24'h0007EC || d512q[b+511] !== 32'hDEAD01FF) begin failures++; $display("[TB] FAIL w512_last got=(%h,%h) want=(0007ec,dead01ff)", a512q[b+511], d512q[b+511]); end
      for (int i = 0; i < 512; i++)
         if (a512q[b+i] !== 24'hFFFFF0 + 24'(4*i) || d512q[b+i] !== 32'hDEAD0000 + 32'(i)) bad++;
      checks++; if (bad != 0) begin failures++; $display("[TB] FAIL w512_sequence bad_words got=%0d want=0", bad); end
      checks++; if (maxPa512 !== 9'd511) begin failures++; $display("[TB] FAIL w512_max_prom_addr got=%0d want=511", maxPa512); end
      checks++; if (done512Cyc - s != 1536 || done512Cnt - d0 != 1) begin failures++; $display("[TB] FAIL w512_done latency=%0d pulses=%0d want 1536 1", done512Cyc - s, done512Cnt - d0); end
      checks++; if (overlap512 - o0 != 0) begin failures++; $display("[TB] FAIL w512_en_valid_overlap got=%0d want=0", overlap512 - o0); end
   endtask

   task automatic test_words1;
      bit ok;
      int s, b, d0;
      b = a1q.size(); d0 = done1Cnt;
      pulseStart(1, s);
      waitIdle(1, 20, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL w1_timeout busy=%0b want=0", busy1); end
      checks++; if (a1q.size() - b != 1) begin failures++; $display("[TB] FAIL w1_count got=%0d want=1", a1q.size() - b); end
      checks++; if (a1q[b] !== 24'h123450 || d1q[b] !== 32'hA0) begin failures++; $display("[TB] FAIL w1_word got=(%h,%h) want=(123450,a0)", a1q[b], d1q[b]); end
      checks++; if (done1Cyc - s != 3 || done1Cnt - d0 != 1) begin failures++; $display("[TB] FAIL w1_done latency=%0d pulses=%0d want 3 1", done1Cyc - s, done1Cnt - d0); end
   endtask

   initial begin
      test_reset;
      test_basic_copy;
      test_stall;
      test_start_while_busy;
      test_reset_mid_write;
      test_words512;
      test_words1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
